// File: rtl/varredura_matriz_linhas_if.sv
// rtl/varredura_matriz_linhas_if.sv - enable, row patterns and matrix drive for the row-scan driver
interface varredura_matriz_linhas_if;
    logic       en;
    logic [4:0] cl1;
    logic [4:0] cl2;
    logic [4:0] cl3;
    logic [4:0] cl4;
    logic [4:0] cl5;
    logic [4:0] cl6;
    logic [4:0] cl7;
    logic [6:0] linha;
    logic [4:0] coluna;
    logic [2:0] linha_idx;
    logic       fim_quadro;

    modport master (
        output en, cl1, cl2, cl3, cl4, cl5, cl6, cl7,
        input  linha, coluna, linha_idx, fim_quadro
    );

    modport slave (
        input  en, cl1, cl2, cl3, cl4, cl5, cl6, cl7,
        output linha, coluna, linha_idx, fim_quadro
    );
endinterface

// File: rtl/varredura_matriz_linhas.sv
// rtl/varredura_matriz_linhas.sv - 5x7 dot-matrix row scanner with per-frame pattern snapshot
module varredura_matriz_linhas #(
    parameter int DIV   = 50000,
    parameter int BLANK = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    varredura_matriz_linhas_if.slave   bus
);
    localparam int            CW       = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_C  = CW'(BLANK);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [6:0][4:0]   snap_q, snap_d;
    logic [6:0]        linha_q, linha_d;
    logic [4:0]        coluna_q, coluna_d;
    logic [2:0]        linha_idx_q, linha_idx_d;
    logic              fim_quadro_q, fim_quadro_d;
    logic              blank;

    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        blank        = !bus.en || (cnt_q < BLANK_C);
        linha_d      = 7'h7F;
        coluna_d     = 5'h00;
        linha_idx_d  = idx_q;
        fim_quadro_d = 1'b0;

        if (bus.en) begin
            // Snapshot only at frame start; that cycle is always blank, so no tearing.
            if (cnt_q == '0 && idx_q == 3'd0) begin
                snap_d = {bus.cl7, bus.cl6, bus.cl5, bus.cl4, bus.cl3, bus.cl2, bus.cl1};
            end
            if (cnt_q == DIV_M1) begin
                cnt_d = '0;
                idx_d = (idx_q == 3'd6) ? 3'd0 : idx_q + 3'd1;
                fim_quadro_d = (idx_q == 3'd6);
            end else begin
                cnt_d = cnt_q + ONE_C;
            end
        end

        if (!blank) begin
            linha_d  = ~(7'b1 << idx_q);
            coluna_d = snap_q[idx_q];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            snap_q       <= '0;
            linha_q      <= 7'h7F;
            coluna_q     <= 5'h00;
            linha_idx_q  <= 3'd0;
            fim_quadro_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            linha_q      <= linha_d;
            coluna_q     <= coluna_d;
            linha_idx_q  <= linha_idx_d;
            fim_quadro_q <= fim_quadro_d;
        end
    end

    assign bus.linha      = linha_q;
    assign bus.coluna     = coluna_q;
    assign bus.linha_idx  = linha_idx_q;
    assign bus.fim_quadro = fim_quadro_q;
endmodule
